// File: rtl/intt.sv
//==============================================================================
// Module   : intt
// Brief    : 256-point in-place Gentleman-Sande inverse NTT over Z_Q, Q = 8380417.
//            Define INTT_SCALE_EN to scale outputs by 256^-1 (exact inverse).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module intt #(
    parameter int DATA_W = 23,
    parameter int Q      = 8380417
`ifdef INTT_SCALE_EN
    ,
    parameter int N_INV  = 8347681
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              input_ready,
    input  logic              input_valid,
    input  logic [DATA_W-1:0] input_data,
    output logic [7:0]        tf_addr,
    input  logic [DATA_W-1:0] tf_data,
    output logic              output_valid,
    output logic [DATA_W-1:0] output_data
);

    localparam logic [DATA_W-1:0] Q_W = DATA_W'(Q);
    localparam logic [DATA_W:0]   Q24 = (DATA_W + 1)'(Q);
`ifdef INTT_SCALE_EN
    localparam logic [DATA_W-1:0] N_INV_W = DATA_W'(N_INV);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CALC   = 3'd2,
        J_LOOP = 3'd3,
        START  = 3'd4,
        LEN    = 3'd5,
        OUTPUT = 3'd6
    } state_t;

    // Full reduction of a 46-bit product, folding with 2^23 == 2^13 - 1 (mod Q).
    // Three folds bring the value below 2Q, so one conditional subtract finishes it.
    function automatic logic [22:0] mod_mul(input logic [22:0] a, input logic [22:0] b);
        logic [45:0] p;
        logic [36:0] t1;
        logic [27:0] t2;
        logic [23:0] t3;
        logic [23:0] t3_red;
        p      = {23'd0, a} * {23'd0, b};
        t1     = {1'b0, p[45:23], 13'd0} - {14'd0, p[45:23]} + {14'd0, p[22:0]};
        t2     = {1'b0, t1[36:23], 13'd0} - {14'd0, t1[36:23]} + {5'd0, t1[22:0]};
        t3     = {6'd0, t2[27:23], 13'd0} - {19'd0, t2[27:23]} + {1'b0, t2[22:0]};
        t3_red = t3 - Q24;
        return (t3 >= Q24) ? t3_red[22:0] : t3[22:0];
    endfunction

    logic [DATA_W-1:0] mem [256];

    state_t      state;
    logic [7:0]  in_cnt;
    logic [7:0]  out_cnt;
    logic [7:0]  m;
    logic [8:0]  j;
    logic [8:0]  start;
    logic [8:0]  len;

    logic [7:0]        idx_lo;
    logic [7:0]        idx_hi;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] w;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sum_red;
    logic [DATA_W-1:0] bf_sum;
    logic [DATA_W-1:0] bf_diff;
    logic [DATA_W-1:0] bf_prod;
    logic [8:0]        next_start;
    logic [DATA_W-1:0] out_word;
    logic [DATA_W-1:0] out_scaled;
    logic              accept;

    assign input_ready = (state == IDLE) || (state == LOAD);
    assign accept      = input_ready && input_valid;
    assign tf_addr     = 8'd255 - m;

    // Butterfly datapath: both operands read asynchronously from the register file.
    assign idx_lo  = j[7:0];
    assign idx_hi  = j[7:0] + len[7:0];
    assign x       = mem[idx_lo];
    assign y       = mem[idx_hi];
    assign w       = (tf_data == '0) ? '0 : (Q_W - tf_data);
    assign sum     = {1'b0, x} + {1'b0, y};
    assign sum_red = sum - Q24;
    assign bf_sum  = (sum >= Q24) ? sum_red[DATA_W-1:0] : sum[DATA_W-1:0];
    assign bf_diff = (x >= y) ? (x - y) : (x + (Q_W - y));
    assign bf_prod = mod_mul(w, bf_diff);

    assign next_start = start + {len[7:0], 1'b0};

    assign out_word = mem[out_cnt];
`ifdef INTT_SCALE_EN
    assign out_scaled = mod_mul(out_word, N_INV_W);
`else
    assign out_scaled = out_word;
`endif

    // Coefficient storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[in_cnt] <= input_data;
        end else if (state == CALC) begin
            mem[idx_lo] <= bf_sum;
            mem[idx_hi] <= bf_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            output_valid <= 1'b0;
            output_data  <= '0;
            in_cnt       <= 8'd0;
            out_cnt      <= 8'd0;
            j            <= 9'd0;
            start        <= 9'd0;
            m            <= 8'd0;
            len          <= 9'd1;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    output_valid <= 1'b0;
                    if (input_valid) begin
                        in_cnt <= in_cnt + 8'd1;
                        if (in_cnt == 8'd255) begin
                            state <= CALC;
                            j     <= 9'd0;
                            start <= 9'd0;
                            m     <= 8'd0;
                            len   <= 9'd1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                CALC: begin
                    state <= J_LOOP;
                end
                J_LOOP: begin
                    j <= j + 9'd1;
                    if (j < start + len - 9'd1) begin
                        state <= CALC;
                    end else begin
                        state <= START;
                    end
                end
                START: begin
                    start <= next_start;
                    j     <= next_start;
                    m     <= m + 8'd1;
                    if (next_start < 9'd256) begin
                        state <= CALC;
                    end else begin
                        state <= LEN;
                    end
                end
                LEN: begin
                    len   <= {len[7:0], 1'b0};
                    start <= 9'd0;
                    j     <= 9'd0;
                    if (len < 9'd128) begin
                        state <= CALC;
                    end else begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    output_valid <= 1'b1;
                    output_data  <= out_scaled;
                    out_cnt      <= out_cnt + 8'd1;
                    if (out_cnt == 8'd255) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_intt.sv
//==============================================================================
// Module   : tb_intt
// Brief    : Self-checking bench for intt: forward-NTT golden model, zeta ROM,
//            scoreboard queue of expected outputs, latency and twiddle checks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_intt;

    localparam int Q = 8380417;
    localparam longint unsigned QL = 64'd8380417;
`ifdef INTT_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    localparam int K_ZERO  = 0;
    localparam int K_DELTA = 1;
    localparam int K_RAND  = 2;

    typedef struct {
        string name;
        int    kind;
        int    seed;
        int    gap_at;
        int    gap_len;
        int    exp0;      // expected word 0, or -1 to use the golden model
        int    exp_rest;  // expected words 1..255, or -1 to use the golden model
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_ready;
    logic        input_valid;
    logic [22:0] input_data;
    logic [7:0]  tf_addr;
    logic [22:0] tf_data;
    logic        output_valid;
    logic [22:0] output_data;

    logic [22:0] zeta_rom [256];
    logic [22:0] x_vec    [256];
    logic [22:0] in_vec   [256];
    int          tf_exp   [2311];
    logic [22:0] exp_q    [$];
    logic [22:0] mon_exp;
    logic [22:0] last_exp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tf_data = zeta_rom[tf_addr];

    intt dut (
        .clk          (clk),
        .rst          (rst),
        .input_ready  (input_ready),
        .input_valid  (input_valid),
        .input_data   (input_data),
        .tf_addr      (tf_addr),
        .tf_data      (tf_data),
        .output_valid (output_valid),
        .output_data  (output_data)
    );

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int brv8(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) r = r | (((k >> i) & 1) << (7 - i));
        return r;
    endfunction

    function automatic longint unsigned mulq(input longint unsigned a, input longint unsigned b);
        return (a * b) % QL;
    endfunction

    // Forward NTT (Cooley-Tukey, zetas[1..255] in increasing order): in_vec = NTT(x_vec).
    task automatic fwd_ntt();
        longint unsigned a [256];
        longint unsigned t;
        longint unsigned z;
        int k;
        for (int i = 0; i < 256; i++) a[i] = 64'(x_vec[i]);
        k = 0;
        for (int ln = 128; ln > 0; ln = ln / 2) begin
            for (int s = 0; s < 256; s = s + 2 * ln) begin
                k++;
                z = 64'(zeta_rom[k]);
                for (int jj = s; jj < s + ln; jj++) begin
                    t         = mulq(z, a[jj + ln]);
                    a[jj + ln] = (a[jj] + QL - t) % QL;
                    a[jj]      = (a[jj] + t) % QL;
                end
            end
        end
        for (int i = 0; i < 256; i++) in_vec[i] = 23'(a[i]);
    endtask

    task automatic gen_x(input int seed);
        longint unsigned st;
        st = 64'(seed) * 64'd2654435761 + 64'd12345;
        for (int i = 0; i < 256; i++) begin
            st       = st * 64'd6364136223846793005 + 64'd1442695040888963407;
            x_vec[i] = 23'((st >> 33) % QL);
        end
    endtask

    task automatic feed(input int gap_at, input int gap_len);
        for (int i = 0; i < 256; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    input_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    check("gap_input_ready", input_ready, 1);
                end
            end
            @(negedge clk);
            input_valid = 1'b1;
            input_data  = in_vec[i];
        end
        @(posedge clk);  // edge that accepts coefficient 255
    endtask

    // Scoreboard consumer: one expected word per valid output cycle.
    always @(negedge clk) begin
        if (output_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d with no expected word queued", output_data);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (output_data !== mon_exp) begin
                    errors++;
                    $display("FAIL output_word: got %0d, expected %0d (%0d words left)",
                             output_data, mon_exp, exp_q.size());
                end
                last_exp = mon_exp;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int k;
        int seen;
        int tf_err;
        int tf_first;
        int burst;
        longint unsigned e;
        for (int i = 0; i < 256; i++) x_vec[i] = 23'd0;
        if (v.kind == K_DELTA) x_vec[0] = 23'd1;
        if (v.kind == K_RAND) gen_x(v.seed);
        fwd_ntt();
        for (int i = 0; i < 256; i++) begin
            if (v.exp0 >= 0) e = (i == 0) ? 64'(v.exp0) : 64'(v.exp_rest);
            else if (SCALED) e = 64'(x_vec[i]);
            else e = (64'(x_vec[i]) * 64'd256) % QL;
            exp_q.push_back(23'(e));
        end
        feed(v.gap_at, v.gap_len);
        #1;
        input_valid = 1'b0;
        k        = 0;
        seen     = 0;
        tf_err   = 0;
        tf_first = -1;
        while (seen == 0 && k < 2400) begin
            if (output_valid) begin
                seen = 1;
            end else begin
                if (k < 2311 && int'(tf_addr) != tf_exp[k]) begin
                    tf_err++;
                    if (tf_first < 0) tf_first = k;
                end
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({v.name, "_latency"}, k, 2312);
        check({v.name, "_tf_addr_mismatches"}, tf_err, 0);
        if (tf_first >= 0) check({v.name, "_tf_first_bad_cycle"}, tf_first, -1);
        burst = 0;
        while (output_valid && burst < 300) begin
            @(posedge clk);
            #1;
            burst++;
        end
        check({v.name, "_valid_burst"}, burst, 256);
        check({v.name, "_words_left"}, exp_q.size(), 0);
        check({v.name, "_data_hold"}, output_data, last_exp);
        check({v.name, "_ready_idle"}, input_ready, 1);
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs [23];
        int   mm;
        int   n;
        longint unsigned z;

        vecs[0] = '{"zeros", K_ZERO, 0, -1, 0, 0, 0};
        vecs[1] = '{"delta", K_DELTA, 0, -1, 0, SCALED ? 1 : 256, 0};
        for (int r = 0; r < 20; r++) vecs[2 + r] = '{"random", K_RAND, r + 1, -1, 0, -1, -1};
        vecs[22] = '{"gap", K_RAND, 3, 100, 10, -1, -1};

        for (int k = 0; k < 256; k++) begin
            z = 64'd1;
            for (int e = 0; e < brv8(k); e++) z = mulq(z, 64'd1753);
            zeta_rom[k] = 23'(z);
        end

        // Expected tf_addr on every compute cycle after the final accept.
        mm = 0;
        n  = 0;
        for (int ln = 1; ln < 256; ln = ln * 2) begin
            for (int s = 0; s < 256; s = s + 2 * ln) begin
                for (int b = 0; b < 2 * ln + 1; b++) begin
                    tf_exp[n] = 255 - mm;
                    n++;
                end
                mm++;
            end
            tf_exp[n] = 255 - mm;
            n++;
        end

        rst         = 1'b1;
        input_valid = 1'b0;
        input_data  = 23'd0;
        last_exp    = 23'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_output_valid", output_valid, 0);
        check("reset_output_data", output_data, 0);
        check("reset_input_ready", input_ready, 1);
        check("reset_tf_addr", tf_addr, 255);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", input_ready, 1);

        for (int v = 0; v < 23; v++) run_vec(vecs[v]);

        // Abort a frame mid-compute, then confirm a clean frame afterwards.
        gen_x(99);
        fwd_ntt();
        feed(-1, 0);
        #1;
        input_valid = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midcalc_rst_output_valid", output_valid, 0);
        check("midcalc_rst_input_ready", input_ready, 1);
        check("midcalc_rst_tf_addr", tf_addr, 255);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{"post_reset", K_RAND, 7, -1, 0, -1, -1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
